// File: rtl/silencer.sv
// silencer: per-channel slew limiter for duty and phase, one channel per clock over a 2-stage pipeline.
// Define SILENCER_PHASE_FILTER_EN to step phase modulo CYCLE; otherwise phase passes straight through.
module silencer #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 10
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [DEPTH-1:0][WIDTH-1:0]   CYCLE,
  input  logic [15:0]                   STEP,
  input  logic [DEPTH-1:0][WIDTH-1:0]   DUTY_IN,
  input  logic [DEPTH-1:0][WIDTH-1:0]   PHASE_IN,
  input  logic                          START,
  output logic [DEPTH-1:0][WIDTH-1:0]   DUTY_OUT,
  output logic [DEPTH-1:0][WIDTH-1:0]   PHASE_OUT,
  output logic                          DONE
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  typedef enum logic [1:0] {HOLD, TAKE, UP, DOWN} sel_t;
  state_t state, state_nx;
  sel_t d_sel, s1_dsel;
  logic load, fin_d, s1_valid;
  logic [IW-1:0] idx, s1_idx;
  logic [DEPTH-1:0][WIDTH-1:0] duty_snap, phase_snap;
  logic [15:0] step_snap;
  logic [WIDTH-1:0] dt, dc, d_mag, d_next, p_next, pt, s1_dt, s1_dc, s1_s, s1_pt;
  logic [WIDTH:0] d_diff;
  always_comb begin
    load = state == IDLE && START;
    state_nx = load ? RUN : state == RUN && idx == IW'(DEPTH - 1) ? FINISH : state == FINISH ? IDLE : state;
  end
  assign dt = duty_snap[idx];
  assign dc = DUTY_OUT[idx];
  assign d_diff = {1'b0, dt} - {1'b0, dc};
  assign d_mag = d_diff[WIDTH] ? WIDTH'(-d_diff) : d_diff[WIDTH-1:0];
  // STEP=0 means bypass, so it must take the target rather than add zero
  assign d_sel = step_snap == '0 || 32'(d_mag) <= 32'(step_snap) ? TAKE : d_diff[WIDTH] ? DOWN : UP;
  assign d_next = s1_dsel == TAKE ? s1_dt : s1_dsel == UP ? s1_dc + s1_s : s1_dc - s1_s;
`ifdef SILENCER_PHASE_FILTER_EN
  logic [DEPTH-1:0][WIDTH-1:0] cycle_snap;
  logic [WIDTH-1:0] cy, p_raw, pc, f, g, p_min, s1_pc, s1_cy, p_up, p_dn;
  logic [WIDTH:0] up_sum;
  sel_t p_sel, s1_psel;
  assign cy = cycle_snap[idx];
  assign p_raw = phase_snap[idx];
  assign pt = p_raw >= cy ? p_raw - cy : p_raw;
  assign pc = PHASE_OUT[idx];
  assign f = pt >= pc ? pt - pc : pt - pc + cy;
  assign g = cy - f;
  assign p_min = f < g ? f : g;
  // ties at exactly half a cycle step upward
  assign p_sel = step_snap == '0 ? TAKE : f == '0 ? HOLD : 32'(p_min) <= 32'(step_snap) ? TAKE : f <= cy >> 1 ? UP : DOWN;
  assign up_sum = {1'b0, s1_pc} + {1'b0, s1_s};
  assign p_up = up_sum >= {1'b0, s1_cy} ? WIDTH'(up_sum - {1'b0, s1_cy}) : up_sum[WIDTH-1:0];
  assign p_dn = s1_pc >= s1_s ? s1_pc - s1_s : s1_pc + s1_cy - s1_s;
  assign p_next = s1_cy == '0 ? '0 : s1_psel == TAKE ? s1_pt : s1_psel == HOLD ? s1_pc : s1_psel == UP ? p_up : p_dn;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      cycle_snap <= '0;
      s1_pc <= '0;
      s1_cy <= '0;
      s1_psel <= HOLD;
    end else begin
      if (load) cycle_snap <= CYCLE;
      s1_pc <= pc;
      s1_cy <= cy;
      s1_psel <= p_sel;
    end
`else
  assign pt = phase_snap[idx];
  assign p_next = s1_pt;
`endif
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= IDLE;
      idx <= '0;
      fin_d <= 1'b0;
      DONE <= 1'b0;
      duty_snap <= '0;
      phase_snap <= '0;
      step_snap <= '0;
      s1_valid <= 1'b0;
      s1_idx <= '0;
      s1_dsel <= HOLD;
      s1_dt <= '0;
      s1_dc <= '0;
      s1_s <= '0;
      s1_pt <= '0;
      DUTY_OUT <= '0;
      PHASE_OUT <= '0;
    end else begin
      state <= state_nx;
      idx <= state == RUN && state_nx == RUN ? idx + 1'b1 : '0;
      fin_d <= state == FINISH;
      DONE <= fin_d;
      if (load) begin
        duty_snap <= DUTY_IN;
        phase_snap <= PHASE_IN;
        step_snap <= STEP;
      end
      s1_valid <= state == RUN;
      s1_idx <= idx;
      s1_dsel <= d_sel;
      s1_dt <= dt;
      s1_dc <= dc;
      s1_s <= WIDTH'(step_snap);
      s1_pt <= pt;
      if (s1_valid) begin
        DUTY_OUT[s1_idx] <= d_next;
        PHASE_OUT[s1_idx] <= p_next;
      end
    end
endmodule

// File: tb/tb_silencer.sv
// tb_silencer: directed passes against a behavioural scoreboard of per-channel duty/phase updates.
module tb_silencer;
  localparam int W = 13, D = 10;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, done;
  logic [D-1:0][W-1:0] cyc, din, pin, dout, pout;
  logic [15:0] step;
  typedef struct { int ch; int duty; int phase; } exp_t;
  exp_t sb[$];
  int md[D], mp[D];
  int n_assert = 0, n_fail = 0;
  always #5 clk = ~clk;
  silencer #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK(clk), .RST_N(rst_n), .CYCLE(cyc), .STEP(step), .DUTY_IN(din), .PHASE_IN(pin),
    .START(start), .DUTY_OUT(dout), .PHASE_OUT(pout), .DONE(done)
  );
  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int duty_m(int d, int c, int s);
    if (s == 0) return d;
    if (d > c) return (d - c <= s) ? d : c + s;
    return (c - d <= s) ? d : c - s;
  endfunction
  function automatic int phase_m(int p, int c, int cy, int s);
`ifdef SILENCER_PHASE_FILTER_EN
    int t, f, g;
    if (cy == 0) return 0;
    t = p >= cy ? p - cy : p;
    if (s == 0) return t;
    f = ((t - c) % cy + cy) % cy;
    if (f == 0) return c;
    g = cy - f;
    if ((f < g ? f : g) <= s) return t;
    return f <= cy / 2 ? (c + s) % cy : (c - s + cy) % cy;
`else
    return p + 0 * (c + cy + s);
`endif
  endfunction
  task automatic randomize_inputs();
    for (int i = 0; i < D; i++) begin
      din[i] = W'($urandom);
      pin[i] = W'($urandom);
    end
  endtask
  task automatic run_pass(input int repulse, input int rst_at);
    exp_t e;
    int old0, old_last;
    old0 = md[0];
    old_last = md[D-1];
    for (int i = 0; i < D; i++) begin
      e.ch = i;
      e.duty = duty_m(int'(din[i]), md[i], int'(step));
      e.phase = phase_m(int'(pin[i]), mp[i], int'(cyc[i]), int'(step));
      md[i] = e.duty;
      mp[i] = e.phase;
      sb.push_back(e);
    end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    if (repulse != 0) begin
      randomize_inputs();
      step = 16'd1;
    end
    for (int k = 1; k <= D + 4; k++) begin
      start = k == repulse;
      @(negedge clk);
      if (k == rst_at) begin
        #2 rst_n = 1'b0;
        #1 check("async reset outputs", int'(|{dout, pout, done}), 0);
        sb.delete();
        for (int i = 0; i < D; i++) begin
          md[i] = 0;
          mp[i] = 0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < D + 4; j++) begin
          @(negedge clk);
          check("no done after abort", int'(done), 0);
        end
        return;
      end
      check("done timing", int'(done), int'(k == D + 2));
      if (k == 1) check("ch0 held", int'(dout[0]), old0);
      if (k == D) check("last ch held", int'(dout[D-1]), old_last);
      if (k >= 2 && k < D + 2) begin
        if (sb.size() == 0) check("scoreboard empty", 1, 0);
        else begin
          e = sb.pop_front();
          check($sformatf("duty ch%0d", e.ch), int'(dout[e.ch]), e.duty);
          check($sformatf("phase ch%0d", e.ch), int'(pout[e.ch]), e.phase);
        end
      end
    end
  endtask
  initial begin
    cyc = '0;
    din = '0;
    pin = '0;
    step = '0;
    for (int i = 0; i < D; i++) begin
      md[i] = 0;
      mp[i] = 0;
    end
    repeat (3) @(negedge clk);
    check("reset duty", int'(|dout), 0);
    check("reset phase", int'(|pout), 0);
    check("reset done", int'(done), 0);
    rst_n = 1'b1;
    step = 16'd100;
    for (int i = 0; i < D; i++) begin
      din[i] = W'(1000);
      cyc[i] = W'(4096);
      pin[i] = W'(i * 300);
    end
    run_pass(0, 0);
    for (int i = 0; i < D; i++) check("first pass duty 100", int'(dout[i]), 100);
    step = 16'd0;
    run_pass(0, 0);
    step = 16'd100;
    for (int i = 0; i < D; i++) din[i] = W'(950);
    run_pass(0, 0);
    check("duty 950", int'(dout[3]), 950);
    din = '0;
    repeat (10) run_pass(0, 0);
    check("duty floor 0", int'(dout[0]), 0);
    step = 16'd0;
    pin[0] = W'(4000);
    pin[1] = '0;
    cyc[2] = '0;
    pin[2] = W'(500);
    run_pass(0, 0);
    step = 16'd50;
    pin[0] = W'(100);
    repeat (4) run_pass(0, 0);
`ifdef SILENCER_PHASE_FILTER_EN
    check("phase wrap end", int'(pout[0]), 100);
`endif
    step = 16'd0;
    pin = '0;
    run_pass(0, 0);
    step = 16'd10;
    pin[1] = W'(2048);
    pin[2] = W'(2048);
    run_pass(0, 0);
`ifdef SILENCER_PHASE_FILTER_EN
    check("phase tie up", int'(pout[1]), 10);
    check("phase cycle 0", int'(pout[2]), 0);
`else
    check("phase passthrough", int'(pout[1]), 2048);
`endif
    for (int i = 0; i < D; i++) cyc[i] = W'($urandom_range(4096, 8191));
    cyc[5] = '0;
    randomize_inputs();
    step = 16'd0;
    run_pass(0, 0);
    randomize_inputs();
    step = 16'($urandom_range(1, 3000));
    run_pass(0, 0);
    step = 16'd20000;
    randomize_inputs();
    run_pass(5, 0);
    step = 16'd100;
    run_pass(0, 4);
    for (int i = 0; i < D; i++) begin
      din[i] = W'(1000);
      pin[i] = '0;
      cyc[i] = W'(4096);
    end
    run_pass(0, 0);
    check("restart from 0", int'(dout[D-1]), 100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/silencer.md
SILENCER -- requirements
Module: silencer

Interface
Parameters:
REQ-001 SHALL have parameter WIDTH, default 13, giving the bit width of duty, phase and cycle values.
REQ-002 SHALL have parameter DEPTH, default 10, giving the number of transducer channels.

Ports:
REQ-003 SHALL have port CLK, input, 1 bit: the single system clock (20.48 MHz domain); all logic is on its rising edge.
REQ-004 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port CYCLE, input, DEPTH x WIDTH bits: per-channel period; the modulo for phase.
REQ-006 SHALL have port STEP, input, 16 bits: maximum change per update, applied to duty and to phase.
REQ-007 SHALL have port DUTY_IN, input, DEPTH x WIDTH bits: target duties, from the modulator DUTY_OUT.
REQ-008 SHALL have port PHASE_IN, input, DEPTH x WIDTH bits: target phases, from the modulator PHASE_OUT.
REQ-009 SHALL have port START, input, 1 bit: single-cycle pulse meaning the inputs are valid; driven by the modulator DONE.
REQ-010 SHALL have port DUTY_OUT, output, DEPTH x WIDTH bits: silenced duties.
REQ-011 SHALL have port PHASE_OUT, output, DEPTH x WIDTH bits: silenced phases.
REQ-012 SHALL have port DONE, output, 1 bit: single-cycle pulse meaning all channels are updated.

Function
REQ-013 SHALL use a state machine with states IDLE, RUN and FINISH.
- IDLE -> RUN when START=1.
- RUN -> FINISH after channel DEPTH-1 is processed.
- FINISH -> IDLE after exactly one cycle.
REQ-014 SHALL, on the START edge, latch DUTY_IN, PHASE_IN, CYCLE and STEP into snapshot registers; later input changes do not affect the current pass.
REQ-015 SHALL ignore START while the state is RUN or FINISH; there is no queuing.
REQ-016 SHALL process one channel per clock in index order 0..DEPTH-1, with a 2-stage pipeline: difference/compare, then update.
- START sampled at edge t: channel i outputs update at edge t+2+i.
- DONE is high for exactly edge t+DEPTH+2.
REQ-017 SHALL update duty using target d, current c and step s:
- |d-c| <= s: c := d.
- d > c: c := c+s.
- d < c: c := c-s.
- Comparison uses WIDTH+1-bit signed arithmetic; no overflow or underflow is permitted.
REQ-018 SHALL update phase using the forward difference f = (d - c) mod CYCLE:
- f = 0: hold.
- min(f, CYCLE-f) <= s: c := d.
- f <= CYCLE/2 (integer division): c := (c+s) mod CYCLE.
- otherwise: c := (c-s) mod CYCLE, wrapping below 0 to CYCLE-s+c.
REQ-019 SHALL, when f = CYCLE/2 exactly with CYCLE even, step upward (tie-break).
REQ-020 SHALL treat STEP=0 as bypass: each channel output equals its snapshot target at its update edge.
REQ-021 SHALL, for a channel with CYCLE=0, force that channel's PHASE_OUT to 0; duty is processed normally.
REQ-022 SHALL, for PHASE_IN >= CYCLE, reduce the target by CYCLE once before use.
REQ-023 SHALL hold DUTY_OUT and PHASE_OUT constant between updates; each channel changes only at its own update edge.

Reset
REQ-024 SHALL, while RST_N=0 (asynchronous), force state to IDLE, all DUTY_OUT and PHASE_OUT to 0, DONE to 0, and clear the pipeline and snapshots.
REQ-025 SHALL, on reset asserted mid-pass, abort the pass with no DONE; the first START after release begins a full pass from channel 0 with current values 0.

Configuration
REQ-026 SHALL use macro SILENCER_PHASE_FILTER_EN to select phase handling:
- Defined: phase is filtered per REQ-018..REQ-022.
- Undefined: PHASE_OUT[i] is loaded with the snapshot PHASE_IN[i] at channel i's update edge (same latency, no stepping), and the phase arithmetic is not synthesized.
- Duty filtering and timing are identical in both builds.

Verification
REQ-027 SHALL pass: after reset, STEP=100, DUTY_IN all 1000, one START -> DUTY_OUT all 100; DONE exactly 12 cycles after START; channel 0 changes at +2, channel 9 at +11.
REQ-028 SHALL pass: from duty 1000, target 950, STEP=100 -> 950 after one pass; target 0 -> 850, 750, ..., 50, 0 over successive passes, never negative.
REQ-029 SHALL pass (macro defined): CYCLE=4096, current phase 4000, target 100, STEP=50 -> 4050, then 4, then 54, then 100 (wrap path, not down-count).
REQ-030 SHALL pass (macro defined): CYCLE=4096, current 0, target 2048, STEP=10 -> 10 (tie goes upward); CYCLE=0 channel -> PHASE_OUT 0.
REQ-031 SHALL pass: START re-pulsed 5 cycles into a pass -> ignored, exactly one DONE; RST_N low at pass cycle 4 -> all outputs 0 immediately and no DONE.
REQ-032 SHALL pass: STEP=0, random targets -> outputs equal targets after one pass; with the macro undefined, phase equals the target after one pass for any STEP.
